// File: rtl/mine_placer.sv
// Minesweeper board generator: scatters mine_target mines over a 64-cell board,
// drawing candidate cells from a free-running 16-bit LFSR and never mining safe_cell.
module mine_placer #(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  mine_target,
  input  logic [5:0]  safe_cell,
  input  logic        seed_load,
  input  logic [15:0] seed,
  output logic [63:0] mine_map,
  output logic [5:0]  mine_total,
  output logic        busy,
  output logic        done
);

  typedef enum logic [1:0] {IDLE, PLACE, DONE} state_e;

  state_e      state_q;
  logic [15:0] lfsr_q, lfsr_d;
  logic [63:0] map_q;
  logic [5:0]  total_q, target_q, safe_q;
  logic        busy_q, done_q;
  logic [5:0]  cand;
  logic        fb, place_ok;

  // Fibonacci taps 16,14,13,11 for a left-shifting register.
  assign fb   = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
  assign cand = lfsr_q[5:0];
  assign place_ok = (cand != safe_q) && !map_q[cand];

  always_comb begin
    lfsr_d = {lfsr_q[14:0], fb};
    if (state_q == IDLE && seed_load)
      lfsr_d = (seed == 16'h0000) ? LFSR_SEED : seed;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lfsr_q   <= LFSR_SEED;
      map_q    <= '0;
      total_q  <= '0;
      target_q <= '0;
      safe_q   <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            target_q <= mine_target;
            safe_q   <= safe_cell;
            map_q    <= '0;
            total_q  <= '0;
            busy_q   <= 1'b1;
            state_q  <= PLACE;
          end
        end
        PLACE: begin
          // Target check precedes placement so a full board never over-places.
          if (total_q == target_q) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= DONE;
          end else if (place_ok) begin
            map_q[cand] <= 1'b1;
            total_q     <= total_q + 6'd1;
          end
        end
        DONE: begin
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mine_map   = map_q;
  assign mine_total = total_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule
